// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit seven-segment driver.
package seg7_pkg;

  // Display mode selected on accept
  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } disp_mode_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  // Active-low segment patterns (bit 6 = g ... bit 0 = a)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Largest decimal value that fits in n digits: 10^n - 1
  function automatic logic [63:0] dec_max(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_nibble_dec.sv
// Combinational 4-bit value to active-low seven-segment pattern.
module seg7_nibble_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  // Lookup of the glyph for each hex digit
  always_comb begin
    case (nibble_i)
      4'h0:    seg_n_o = 7'h40;
      4'h1:    seg_n_o = 7'h79;
      4'h2:    seg_n_o = 7'h24;
      4'h3:    seg_n_o = 7'h30;
      4'h4:    seg_n_o = 7'h19;
      4'h5:    seg_n_o = 7'h12;
      4'h6:    seg_n_o = 7'h02;
      4'h7:    seg_n_o = 7'h78;
      4'h8:    seg_n_o = 7'h00;
      4'h9:    seg_n_o = 7'h18;
      4'hA:    seg_n_o = 7'h08;
      4'hB:    seg_n_o = 7'h03;
      4'hC:    seg_n_o = 7'h46;
      4'hD:    seg_n_o = 7'h21;
      4'hE:    seg_n_o = 7'h06;
      default: seg_n_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_display_driver.sv
// N-digit seven-segment driver: accept handshake, hex or decimal display
// (sequential double-dabble), leading-zero blanking, overflow dashes and
// per-digit blinking. All segment outputs are registered.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_mode,
  input  logic                    in_lzb,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_n
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int DD_W    = BCD_W + DATA_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0] DEC_LIMIT = dec_max(NUM_DIGITS);

  state_e                  state_q;
  logic                    ready_q;
  logic [DD_W-1:0]         dd_q;        // BCD field on top, binary below
  logic [DD_W-1:0]         dd_adj;
  logic [DD_W-1:0]         dd_shift_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    lzb_q;
  logic                    ovf_pend_q;
  logic [BCD_W-1:0]        digit_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blank_d;
  logic                    overflow_q;
  logic [BLINK_W-1:0]      blink_cnt_q;
  logic                    blink_phase_q;
  logic [7*NUM_DIGITS-1:0] dec_seg;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic                    upper_zero;
  logic [63:0]             data_ext;
  logic                    hex_ovf;
  logic                    dec_ovf;
  logic                    accept;
  disp_mode_e              mode;

  assign accept   = in_valid && ready_q;
  assign mode     = disp_mode_e'(in_mode);
  assign data_ext = 64'(in_data);
  // Bits above the digit field cannot be shown in hex
  assign hex_ovf  = |(data_ext >> BCD_W);
  assign dec_ovf  = data_ext > DEC_LIMIT;

  // One double-dabble iteration: correct BCD nibbles >= 5, then shift left
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dd_q[DATA_W+4*i +: 4] >= 4'd5) begin
        dd_adj[DATA_W+4*i +: 4] = dd_q[DATA_W+4*i +: 4] + 4'd3;
      end
    end
    dd_shift_d = {dd_adj[DD_W-2:0], 1'b0};
  end

  // Leading-zero blank flags from the pending digits, scanning from the top
  always_comb begin
    upper_zero = 1'b1;
    blank_d    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (dd_q[DATA_W+4*i +: 4] == 4'd0);
      if (i != 0) begin
        blank_d[i] = lzb_q && upper_zero;
      end
    end
  end

  // Control FSM: accept, run the conversion, commit digits and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      dd_q       <= '0;
      cnt_q      <= '0;
      lzb_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      digit_q    <= '0;
      blank_q    <= '1;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            lzb_q   <= in_lzb;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (mode == MODE_DEC) begin
              dd_q       <= {{BCD_W{1'b0}}, in_data};
              ovf_pend_q <= dec_ovf;
              state_q    <= ST_CONVERT;
            end else begin
              // Hex digits go straight into the BCD field for a uniform commit
              dd_q       <= {data_ext[BCD_W-1:0], {DATA_W{1'b0}}};
              ovf_pend_q <= hex_ovf;
              state_q    <= ST_COMMIT;
            end
          end
        end
        ST_CONVERT: begin
          dd_q  <= dd_shift_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          digit_q    <= dd_q[DD_W-1:DATA_W];
          blank_q    <= blank_d;
          overflow_q <= ovf_pend_q;
          ready_q    <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running blink timebase; phase flips on every wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      seg7_nibble_dec u_dec (
        .nibble_i (digit_q[4*gi +: 4]),
        .seg_n_o  (dec_seg[7*gi +: 7])
      );
    end
  endgenerate

  // Per-digit glyph selection: blink wins, then overflow dash, then LZB blank
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_phase_q && blink_mask[i]) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else if (overflow_q) begin
        seg_d[7*i +: 7] = SEG_DASH;
      end else if (blank_q[i]) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*i +: 7] = dec_seg[7*i +: 7];
      end
    end
  end

  // Segment output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign in_ready = ready_q;
  assign overflow = overflow_q;
  assign seg_n    = seg_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench for seg7_display_driver (6 digits, 24-bit data, BLINK_DIV=4).
module tb_seg7_display_driver;

  typedef struct packed {
    logic [41:0] seg;
    logic        ovf;
    logic [7:0]  busy;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_mode;
  logic        in_lzb;
  logic [5:0]  blink_mask;
  logic        overflow;
  logic [41:0] seg_n;

  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];

  // Reference blink timebase, plus the phase as seen one edge later
  int   m_cnt;
  logic m_ph;
  logic m_ph_d;

  seg7_display_driver #(
    .NUM_DIGITS (6),
    .DATA_W     (24),
    .BLINK_DIV  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_lzb     (in_lzb),
    .blink_mask (blink_mask),
    .overflow   (overflow),
    .seg_n      (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_ph   <= 1'b0;
      m_ph_d <= 1'b0;
    end else begin
      m_ph_d <= m_ph;
      if (m_cnt == 3) begin
        m_cnt <= 0;
        m_ph  <= ~m_ph;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected display for a value, derived arithmetically
  function automatic exp_t model(input logic [23:0] v, input logic mode, input logic lzb);
    exp_t        e;
    int unsigned t;
    logic [3:0]  d [6];
    int          msd;
    e.busy = mode ? 8'd25 : 8'd1;
    t      = 32'(v);
    e.ovf  = mode && (t > 999999);
    for (int i = 0; i < 6; i++) begin
      if (mode) begin
        d[i] = 4'(t % 10);
        t    = t / 10;
      end else begin
        d[i] = v[4*i +: 4];
      end
    end
    msd = 0;
    for (int i = 0; i < 6; i++) if (d[i] != 4'd0) msd = i;
    for (int i = 0; i < 6; i++) begin
      if (e.ovf)                e.seg[7*i +: 7] = 7'h3F;
      else if (lzb && i > msd)  e.seg[7*i +: 7] = 7'h7F;
      else                      e.seg[7*i +: 7] = dec7(d[i]);
    end
    return e;
  endfunction

  // Offer one value, push its expectation, wait (bounded) for in_ready to return
  task automatic send(input logic [23:0] v, input logic mode, input logic lzb,
                      output int busy, output bit tmo);
    sb_q.push_back(model(v, mode, lzb));
    in_data  = v;
    in_mode  = mode;
    in_lzb   = lzb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    busy = 0;
    tmo  = 1'b0;
    while (in_ready !== 1'b1) begin
      busy++;
      if (busy > 100) begin
        tmo = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (seg_n !== '1) begin n_bad++; $display("FAIL reset_seg got %h want %h", seg_n, 42'h3FFFFFFFFFF); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_vec++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (seg_n !== '1) begin n_bad++; $display("FAIL reset_blank_after got %h want all ones", seg_n); end
    $display("reset  seg_n=%h in_ready=%b overflow=%b", seg_n, in_ready, overflow);
  endtask

  task automatic test_hex();
    logic [23:0] vals [4];
    int   busy;
    bit   tmo;
    exp_t e;
    vals = '{24'h00A5C3, 24'hFFFFFF, 24'h123456, 24'h000000};
    for (int k = 0; k < 4; k++) begin
      send(vals[k], 1'b0, 1'b0, busy, tmo);
      e = sb_q.pop_front();
      n_vec++;
      if (tmo || busy != int'(e.busy)) begin n_bad++; $display("FAIL hex_busy data=%h got %0d want %0d", vals[k], busy, e.busy); end
      n_vec++;
      if (overflow !== e.ovf) begin n_bad++; $display("FAIL hex_ovf data=%h got %b want %b", vals[k], overflow, e.ovf); end
      tick();
      n_vec++;
      if (seg_n !== e.seg) begin n_bad++; $display("FAIL hex_seg data=%h got %h want %h", vals[k], seg_n, e.seg); end
      $display("hex    data=%h seg_n=%h overflow=%b", vals[k], seg_n, overflow);
    end
  endtask

  task automatic test_decimal();
    logic [23:0] vals [4];
    int   busy;
    bit   tmo;
    exp_t e;
    vals = '{24'd123456, 24'd999999, 24'd0, 24'd9};
    for (int k = 0; k < 4; k++) begin
      send(vals[k], 1'b1, 1'b0, busy, tmo);
      e = sb_q.pop_front();
      n_vec++;
      if (tmo || busy != int'(e.busy)) begin n_bad++; $display("FAIL dec_busy data=%0d got %0d want %0d", vals[k], busy, e.busy); end
      n_vec++;
      if (overflow !== e.ovf) begin n_bad++; $display("FAIL dec_ovf data=%0d got %b want %b", vals[k], overflow, e.ovf); end
      tick();
      n_vec++;
      if (seg_n !== e.seg) begin n_bad++; $display("FAIL dec_seg data=%0d got %h want %h", vals[k], seg_n, e.seg); end
      $display("dec    data=%0d seg_n=%h overflow=%b busy=%0d", vals[k], seg_n, overflow, busy);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] vals [3];
    int   busy;
    bit   tmo;
    exp_t e;
    vals = '{24'd1000000, 24'd7, 24'hFFFFFF};
    for (int k = 0; k < 3; k++) begin
      send(vals[k], 1'b1, 1'b1, busy, tmo);
      e = sb_q.pop_front();
      n_vec++;
      if (tmo || busy != int'(e.busy)) begin n_bad++; $display("FAIL ovf_busy data=%0d got %0d want %0d", vals[k], busy, e.busy); end
      n_vec++;
      if (overflow !== e.ovf) begin n_bad++; $display("FAIL ovf_flag data=%0d got %b want %b", vals[k], overflow, e.ovf); end
      tick();
      n_vec++;
      if (seg_n !== e.seg) begin n_bad++; $display("FAIL ovf_seg data=%0d got %h want %h", vals[k], seg_n, e.seg); end
      $display("ovf    data=%0d seg_n=%h overflow=%b", vals[k], seg_n, overflow);
    end
  endtask

  task automatic test_lzb();
    logic [23:0] vals [4];
    logic        modes [4];
    int   busy;
    bit   tmo;
    exp_t e;
    vals  = '{24'h000042, 24'h000000, 24'd1000, 24'h100000};
    modes = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      send(vals[k], modes[k], 1'b1, busy, tmo);
      e = sb_q.pop_front();
      n_vec++;
      if (tmo || busy != int'(e.busy)) begin n_bad++; $display("FAIL lzb_busy data=%h got %0d want %0d", vals[k], busy, e.busy); end
      tick();
      n_vec++;
      if (seg_n !== e.seg) begin n_bad++; $display("FAIL lzb_seg data=%h got %h want %h", vals[k], seg_n, e.seg); end
      $display("lzb    data=%h mode=%b seg_n=%h", vals[k], modes[k], seg_n);
    end
  endtask

  // Hold in_valid high: hex mode must accept every second cycle
  task automatic test_back_to_back();
    logic [23:0] vals [4];
    exp_t e;
    vals     = '{24'h111111, 24'h2468AC, 24'hFEDCBA, 24'h0F0F0F};
    in_mode  = 1'b0;
    in_lzb   = 1'b0;
    in_data  = vals[0];
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      sb_q.push_back(model(vals[k], 1'b0, 1'b0));
      if (k > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (seg_n !== e.seg) begin n_bad++; $display("FAIL b2b_seg idx=%0d got %h want %h", k - 1, seg_n, e.seg); end
        $display("b2b    data=%h seg_n=%h", vals[k-1], seg_n);
      end
      if (k < 3) in_data = vals[k+1];
      else in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_low idx=%0d got %b want 0", k, in_ready); end
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_high idx=%0d got %b want 1", k, in_ready); end
    end
    tick();
    e = sb_q.pop_front();
    n_vec++;
    if (seg_n !== e.seg) begin n_bad++; $display("FAIL b2b_seg idx=3 got %h want %h", seg_n, e.seg); end
    $display("b2b    data=%h seg_n=%h", vals[3], seg_n);
  endtask

  task automatic test_blink();
    int          busy;
    bit          tmo;
    exp_t        e;
    logic [41:0] want;
    int          blanks;
    send(24'h00A5C3, 1'b0, 1'b0, busy, tmo);
    e = sb_q.pop_front();
    tick();
    n_vec++;
    if (seg_n !== e.seg) begin n_bad++; $display("FAIL blink_base got %h want %h", seg_n, e.seg); end
    blink_mask = 6'b000001;
    blanks = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      want = e.seg;
      if (m_ph_d) begin
        want[6:0] = 7'h7F;
        blanks++;
      end
      n_vec++;
      if (seg_n !== want) begin n_bad++; $display("FAIL blink_seg cycle=%0d got %h want %h", c, seg_n, want); end
    end
    $display("blink  mask=%b blank_cycles=%0d of 16", blink_mask, blanks);
    blink_mask = 6'b000000;
    tick();
  endtask

  task automatic test_reset_mid();
    int   busy;
    bit   tmo;
    exp_t prev;
    send(24'h000777, 1'b0, 1'b0, busy, tmo);
    prev = sb_q.pop_front();
    tick();
    in_data  = 24'd123456;
    in_mode  = 1'b1;
    in_lzb   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", in_ready); end
    n_vec++;
    if (seg_n !== prev.seg) begin n_bad++; $display("FAIL mid_retain got %h want %h", seg_n, prev.seg); end
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (seg_n !== '1) begin n_bad++; $display("FAIL mid_rst_seg got %h want all ones", seg_n); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    n_vec++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (seg_n !== '1) begin n_bad++; $display("FAIL mid_after_seg got %h want all ones", seg_n); end
    $display("midrst seg_n=%h in_ready=%b overflow=%b", seg_n, in_ready, overflow);
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_mode    = 1'b0;
    in_lzb     = 1'b0;
    blink_mask = '0;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_lzb();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
